// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based show-ahead FIFO: head word is presented combinationally,
// occupancy tracked by an explicit counter that drives empty/full.
module flip_flop_fifo_with_counter #(
    parameter int width = 8,
    parameter int depth = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(depth - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(depth);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push_acc;
    logic w_pop_acc;

    // Wrap by comparison so non-power-of-two depths index only valid slots.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign empty      = (r_count == '0);
    assign full       = (r_count == FULL_CNT);
    assign w_push_acc = push & (~full | pop);
    assign w_pop_acc  = pop & ~empty;
    assign read_data  = r_mem[r_rd_ptr];

    // NOTE: the data array has no reset; stale words are unreachable once the
    // pointers and count clear, and leaving it unreset keeps it plain flops.
    always_ff @(posedge clk) begin
        if (!rst && w_push_acc) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_flip_flop_fifo_with_counter.sv
// Self-checking bench: directed vector table plus hand sequences and a
// reference-queue random phase for flip_flop_fifo_with_counter.
module tb_flip_flop_fifo_with_counter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] model [$];

    typedef struct {
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] data;
        logic             exp_empty;
        logic             exp_full;
        logic             chk_rd;
        logic [WIDTH-1:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    flip_flop_fifo_with_counter #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given request; reference queue follows along.
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
        bit pa;
        bit qa;
        push       = p;
        pop        = q;
        write_data = d;
        pa = p && ((model.size() < DEPTH) || q);
        qa = q && (model.size() > 0);
        @(posedge clk);
        if (qa) void'(model.pop_front());
        if (pa) model.push_back(d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model.size() == DEPTH));
        if (model.size() > 0) check({tag, "_rd"}, 32'(read_data), 32'(model[0]));
    endtask

    // Requests held high during reset must be ignored.
    task automatic do_reset();
        rst        = 1'b1;
        push       = 1'b1;
        pop        = 1'b1;
        write_data = 8'hEE;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        model.delete();
    endtask

    initial begin
        logic [WIDTH-1:0] pat [5];
        logic [WIDTH-1:0] exp_seq [5];

        pat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

        //            push pop data   empty full chk  rd
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h66};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

        rst = 1'b0; push = 1'b0; pop = 1'b0; write_data = '0;
        @(negedge clk);
        do_reset();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);

        // Fill/empty, push-while-full, pop-while-empty, push+pop-while-empty.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].data);
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].exp_full));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), 32'(read_data), 32'(vecs[i].exp_rd));
        end

        // Back-to-back: two words primed, then 25 push+pop cycles.
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("b2b%0d_rd", i), 32'(read_data), 32'(pat[i % 5]));
            step(1'b1, 1'b1, pat[(i + 2) % 5]);
            check($sformatf("b2b%0d_empty", i), 32'(empty), 32'd0);
            check($sformatf("b2b%0d_full", i),  32'(full),  32'd0);
        end
        check("b2b_tail0", 32'(read_data), 32'(pat[0]));
        step(1'b0, 1'b1, 8'h00);
        check("b2b_tail1", 32'(read_data), 32'(pat[1]));
        step(1'b0, 1'b1, 8'h00);
        check("b2b_drained", 32'(empty), 32'd1);

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, pat[i]);
        check("fpp_full_before", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'hAA);
        check("fpp_full_after", 32'(full), 32'd1);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fpp_rd%0d", i), 32'(read_data), 32'(exp_seq[i]));
            step(1'b0, 1'b1, 8'h00);
        end
        check("fpp_empty", 32'(empty), 32'd1);

        // Reset mid-operation with 3 entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, pat[i + 1]);
        do_reset();
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full",  32'(full),  32'd0);
        step(1'b1, 1'b0, 8'h77);
        check("mid_rst_rd", 32'(read_data), 32'h77);
        check("mid_rst_nonempty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("mid_rst_drain", 32'(empty), 32'd1);

        // Random traffic against the reference queue; push-heavy first half
        // drives the FIFO into full, where push+pop gets exercised.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic p;
            logic q;
            if (i < 150) begin
                p = ($urandom_range(0, 9) < 7);
                q = ($urandom_range(0, 9) < 4);
            end else begin
                p = ($urandom_range(0, 9) < 4);
                q = ($urandom_range(0, 9) < 6);
            end
            step(p, q, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
